// File: rtl/spi_slave_if.sv
// Bundle of SPI pins plus core-side RX/TX handshake between a master-side agent and spi_slave.
interface spi_slave_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_ready;
  logic       busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_wr,
    output miso, miso_oe, rx_data, rx_valid, tx_ready, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_wr,
    input  miso, miso_oe, rx_data, rx_valid, tx_ready, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled on the system clock. MSB-first 8-bit frames,
// received bytes delivered with a one-clock strobe, transmit bytes taken from a 1-deep buffer.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // After reset the synchronizers hold idle values; edges are ignored until they have
  // refilled from the pins so a frame already in progress is not mistaken for a new one.
  localparam int                   FLUSH_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0]   FLUSH_CNT = FLUSH_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [FLUSH_W-1:0]     r_flush_cnt;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_buf;
  logic       r_tx_ready;
  logic       r_miso;
  logic       r_miso_oe;
  logic       r_busy;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;

  logic       w_sclk_s;
  logic       w_cs_s;
  logic       w_mosi_s;
  logic       w_armed;
  logic       w_cs_edge;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_load;
  logic [7:0] w_next_byte;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_armed   = (r_flush_cnt == {FLUSH_W{1'b0}});
  assign w_cs_edge = w_cs_s ^ r_cs_d;
  assign w_cs_fall = w_armed & r_cs_d & ~w_cs_s;
  assign w_cs_rise = w_armed & ~r_cs_d & w_cs_s;
  // sclk edges coinciding with a cs_n edge are dropped
  assign w_sclk_rise = w_armed & ~w_cs_edge & ~r_sclk_d & w_sclk_s;
  assign w_sclk_fall = w_armed & ~w_cs_edge & r_sclk_d & ~w_sclk_s;

  // A new transmit byte is taken at frame start and at each byte boundary on sclk fall
  assign w_load = ((r_state == ST_IDLE) & w_cs_fall) |
                  ((r_state == ST_ACTIVE) & w_sclk_fall & (r_bit_cnt == 3'd0));
  assign w_next_byte = r_tx_ready ? IDLE_BYTE : r_tx_buf;

  assign bus.miso     = r_miso;
  assign bus.miso_oe  = r_miso_oe;
  assign bus.busy     = r_busy;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.tx_ready = r_tx_ready;

  // Pin synchronizers, one-cycle-delayed copies for edge detection, post-reset flush counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_flush_cnt <= FLUSH_CNT;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      if (!w_armed) begin
        r_flush_cnt <= r_flush_cnt - FLUSH_W'(1);
      end
    end
  end

  // Frame FSM with shift registers, TX buffer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_tx_buf   <= 8'h00;
      r_tx_ready <= 1'b1;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;

      // A load sees the buffer as it was before any same-cycle write
      if (w_load && !r_tx_ready) begin
        r_tx_ready <= 1'b1;
      end else if (bus.tx_wr && r_tx_ready) begin
        r_tx_buf   <= bus.tx_data;
        r_tx_ready <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state    <= ST_ACTIVE;
            r_miso_oe  <= 1'b1;
            r_busy     <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_tx_shift <= w_next_byte;
            r_miso     <= w_next_byte[7];
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= ST_IDLE;
            r_miso_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_bit_cnt <= 3'd0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_data  <= {r_rx_shift[6:0], w_mosi_s};
              r_rx_valid <= 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_bit_cnt != 3'd0) begin
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              r_miso     <= r_tx_shift[6];
            end else begin
              r_tx_shift <= w_next_byte;
              r_miso     <= w_next_byte[7];
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_miso_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_bit_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule
